iir_coeff_bank: RTL

- Receive side of the IIR integrator coefficient-load interface (reg_select / enable_reg_select / coefficient), as driven by the pedestal-recovery configuration FSM.
- Collects writes into a shadow bank and tracks which slots are written.
- Atomically commits the complete set to an active bank when the filter enables.
- Provides the active coefficients to the filter datapath, plus readback and error status for slow control.

---
 rtl/iir_coeff_bank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iir_coeff_bank.sv
// Coefficient bank for the IIR integrator. Writes are collected in a shadow bank,
// and the complete set is copied into the active bank when the filter is enabled.
module iir_coeff_bank #(
    parameter int NUM_COEF = 5,
    parameter int COEF_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       enable_reg_select,
    input  logic [2:0]                 reg_select,
    input  logic [COEF_W-1:0]          coefficient,
    input  logic [2:0]                 rd_select,
    output logic [NUM_COEF*COEF_W-1:0] coef_active,
    output logic                       coef_valid,
    output logic                       commit_pulse,
    output logic [NUM_COEF-1:0]        written_mask,
    output logic [1:0]                 cfg_error,
    output logic [COEF_W-1:0]          rd_data
);
    // state      | meaning
    // ST_IDLE    | nothing written since reset
    // ST_LOADING | collecting shadow writes, set incomplete
    // ST_ARMED   | shadow set complete, waiting for en
    // ST_ACTIVE  | active bank committed, filter may run
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2,
        ST_ACTIVE  = 2'd3
    } state_t;

    localparam logic [3:0]          NUM_COEF_L = 4'(NUM_COEF);
    localparam logic [NUM_COEF-1:0] MASK_FULL  = '1;

    state_t                             state_q, state_d;
    logic [NUM_COEF-1:0][COEF_W-1:0]    shadow_q, shadow_d;
    logic [NUM_COEF-1:0][COEF_W-1:0]    active_q, active_d;
    logic [NUM_COEF-1:0]                mask_q, mask_d;
    logic                               valid_q, valid_d;
    logic                               commit_q, commit_d;
    logic [1:0]                         err_q, err_d;
    logic [COEF_W-1:0]                  rd_q, rd_d;

    logic                               in_range;
    logic                               run_lock;
    logic                               wr_acc;
    logic [NUM_COEF-1:0]                wr_hit;
    logic [NUM_COEF-1:0]                mask_upd;

    always_comb begin
        in_range = ({1'b0, reg_select} < NUM_COEF_L);
        run_lock = (state_q == ST_ACTIVE) && en;
        wr_acc   = enable_reg_select && in_range && !run_lock;

        wr_hit   = '0;
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (wr_acc && (reg_select == 3'(k))) begin
                wr_hit[k]   = 1'b1;
                shadow_d[k] = coefficient;
            end
        end
        mask_upd = mask_q | wr_hit;

        state_d  = state_q;
        mask_d   = mask_upd;
        active_d = active_q;
        valid_d  = valid_q;
        commit_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_acc)
                    state_d = (mask_upd == MASK_FULL) ? ST_ARMED : ST_LOADING;
            end
            ST_LOADING: begin
                if (mask_upd == MASK_FULL)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // shadow_d already carries any same-cycle write, so the commit sees it
                if (en) begin
                    active_d = shadow_d;
                    valid_d  = 1'b1;
                    commit_d = 1'b1;
                    mask_d   = '0;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                mask_d = '0;
                if (wr_acc) begin
                    mask_d  = wr_hit;
                    state_d = (wr_hit == MASK_FULL) ? ST_ARMED : ST_LOADING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        endcase

        err_d = err_q | {enable_reg_select && in_range && run_lock,
                         enable_reg_select && !in_range};

        rd_d = '0;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (rd_select == 3'(k))
                rd_d = active_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    assign coef_active  = active_q;
    assign coef_valid   = valid_q;
    assign commit_pulse = commit_q;
    assign written_mask = mask_q;
    assign cfg_error    = err_q;
    assign rd_data      = rd_q;

endmodule
